fetch_unit: RTL

Front-end fetch stage that sits directly upstream of the instruction memory. It owns the program counter, drives the word address to instruction memory, and registers each returned instruction with its PC into a valid/ready output slot consumed by decode. It supports stall (backpressure), redirect/flush from branch or jump resolution, and a halt state entered on a designated halt encoding.

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory and
// registers each returned word with its PC into a valid/ready slot.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        vld_q, vld_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic        mis_q, mis_d;
  logic [31:0] cnt_q, cnt_d;

  logic        load;
  logic        accept;
  logic        is_halt;
  logic [31:0] redir_al;

  assign is_halt  = (imem_data == HALT_INSTR);
  assign accept   = vld_q && out_ready;
  assign redir_al = {redirect_pc[31:2], 2'b00};
  assign load     = (state_q == RUN)
                  && (!vld_q || out_ready)
                  && !redirect_valid;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: redirect wins, BOOT lasts one cycle, halt word parks.
  always_comb begin
    state_d = state_q;
    priority case (1'b1)
      redirect_valid:     state_d = RUN;
      state_q == BOOT:    state_d = RUN;
      load && is_halt:    state_d = HALT;
      default:            state_d = state_q;
    endcase
  end

  // Outputs decoded from state and the slot registers.
  always_comb begin
    imem_addr    = pc_q;
    halted       = (state_q == HALT);
    out_valid    = vld_q;
    out_instr    = instr_q;
    out_pc       = opc_q;
    misalign_err = mis_q;
    fetch_count  = cnt_q;
  end

  // Datapath next values for PC, slot, error pulse and counter.
  always_comb begin
    pc_d    = pc_q;
    vld_d   = vld_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    mis_d   = 1'b0;
    cnt_d   = accept ? cnt_q + 32'd1 : cnt_q;
    priority case (1'b1)
      redirect_valid: begin
        pc_d  = redir_al;
        vld_d = 1'b0;
        mis_d = |redirect_pc[1:0];
      end
      load: begin
        instr_d = imem_data;
        opc_d   = pc_q;
        vld_d   = 1'b1;
        pc_d    = is_halt ? pc_q : pc_q + 32'd4;
      end
      out_ready: begin
        vld_d = 1'b0;
      end
      default: begin
        vld_d = vld_q;
      end
    endcase
  end

  // Slot, PC and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      instr_q <= 32'h0;
      opc_q   <= 32'h0;
      mis_q   <= 1'b0;
      cnt_q   <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
